escalonador_bloqueio: RTL and testbench

ESCALONADOR_BLOQUEIO -- requirements
Module: escalonador_bloqueio

---
 rtl/escalonador_bloqueio_if.sv | 23 ++
 rtl/escalonador_bloqueio.sv | 131 +++++++++++++
 tb/tb_escalonador_bloqueio.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/escalonador_bloqueio_if.sv
// Handshake bundle between the blocking-line scheduler and the board.
// master drives the target/enable/acknowledge side, slave is the scheduler.
interface escalonador_bloqueio_if;
    logic       enable;
    logic [2:0] linhas_alvo;
    logic       pronto;
    logic       req_inserir;
    logic       req_remover;
    logic [2:0] linha_idx;
    logic [2:0] linhas_ativas;
    logic       ocupado;
    logic       erro;

    modport master (
        output enable, linhas_alvo, pronto,
        input  req_inserir, req_remover, linha_idx, linhas_ativas, ocupado, erro
    );

    modport slave (
        input  enable, linhas_alvo, pronto,
        output req_inserir, req_remover, linha_idx, linhas_ativas, ocupado, erro
    );
endinterface

// File: rtl/escalonador_bloqueio.sv
// Schedules one-line-at-a-time insert/remove requests towards the board until
// linhas_ativas matches the clamped target. Optional cooldown: BLOQ_COOLDOWN_EN.
module escalonador_bloqueio #(
    parameter int MAX_LINHAS      = 7,
    parameter int COOLDOWN_CICLOS = 8,
    parameter int TIMEOUT_CICLOS  = 255
) (
    input logic                   clock,
    input logic                   reset,
    escalonador_bloqueio_if.slave bus
);

    localparam int CMAX = (TIMEOUT_CICLOS > COOLDOWN_CICLOS) ? TIMEOUT_CICLOS : COOLDOWN_CICLOS;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] TMO_FIM = CW'(TIMEOUT_CICLOS - 1);
`ifdef BLOQ_COOLDOWN_EN
    localparam logic [CW-1:0] CD_FIM  = CW'(COOLDOWN_CICLOS - 1);
`endif
    localparam logic [2:0] LIM = 3'(MAX_LINHAS);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        INSERE = 2'd1,
        REMOVE = 2'd2,
        PAUSA  = 2'd3
    } estado_t;

    estado_t       estado, estado_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    ativas, ativas_n;
    logic          erro_q, erro_n;
    logic          armado;
    logic [2:0]    alvo;

    // armado holds off scheduling for the first edge after reset release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            ativas <= '0;
            erro_q <= 1'b0;
            armado <= 1'b0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
            ativas <= ativas_n;
            erro_q <= erro_n;
            armado <= 1'b1;
        end
    end

    always_comb begin
        if ({29'd0, bus.linhas_alvo} > 32'(MAX_LINHAS))
            alvo = LIM;
        else
            alvo = bus.linhas_alvo;
    end

    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        ativas_n = ativas;
        erro_n   = erro_q;
        case (estado)
            OCIOSO: begin
                cnt_n = '0;
                if (armado && bus.enable) begin
                    if (alvo > ativas)
                        estado_n = INSERE;
                    else if (alvo < ativas)
                        estado_n = REMOVE;
                end
            end
            INSERE, REMOVE: begin
                if (bus.pronto) begin
                    cnt_n = '0;
                    if (estado == INSERE) begin
                        if (ativas < LIM)
                            ativas_n = ativas + 3'd1;
                    end else begin
                        if (ativas != 3'd0)
                            ativas_n = ativas - 3'd1;
                    end
`ifdef BLOQ_COOLDOWN_EN
                    estado_n = PAUSA;
`else
                    estado_n = OCIOSO;
`endif
                end else if (cnt == TMO_FIM) begin
                    cnt_n    = '0;
                    erro_n   = 1'b1;
                    estado_n = OCIOSO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PAUSA: begin
`ifdef BLOQ_COOLDOWN_EN
                if (cnt == CD_FIM) begin
                    cnt_n    = '0;
                    estado_n = OCIOSO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
`else
                cnt_n    = '0;
                estado_n = OCIOSO;
`endif
            end
            default: begin
                cnt_n    = '0;
                estado_n = OCIOSO;
            end
        endcase
    end

    always_comb begin
        bus.req_inserir   = (estado == INSERE);
        bus.req_remover   = (estado == REMOVE);
        bus.linhas_ativas = ativas;
        bus.ocupado       = (estado != OCIOSO);
        bus.erro          = erro_q;
        if (estado == INSERE)
            bus.linha_idx = ativas;
        else if (estado == REMOVE)
            bus.linha_idx = ativas - 3'd1;
        else
            bus.linha_idx = '0;
    end

endmodule

// File: tb/tb_escalonador_bloqueio.sv
// Scoreboard bench for escalonador_bloqueio: a line-count model plans the
// expected insert/remove sequence, a monitor checks every handshake/timeout.
module tb_escalonador_bloqueio;

    localparam int MAXL = 5;
    localparam int CD   = 4;
    localparam int TMO  = 20;
`ifdef BLOQ_COOLDOWN_EN
    localparam int GAP_ESP = CD + 1;
`else
    localparam int GAP_ESP = 1;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    escalonador_bloqueio_if bus();

    escalonador_bloqueio #(
        .MAX_LINHAS     (MAXL),
        .COOLDOWN_CICLOS(CD),
        .TIMEOUT_CICLOS (TMO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit rem;
        int idx;
        bit tmo;
    } op_t;

    op_t q[$];
    int  erros   = 0;
    int  checks  = 0;
    int  mdl_cnt = 0;
    bit  mudo    = 0;
    int  ciclo   = 0;
    int  gap     = -1;
    int  hs_ciclo = 0;
    bit  pend    = 0;
    int  pend_exp = 0;
    int  ambos   = 0;

    task automatic check(input string nome, input int atual, input int esperado);
        checks++;
        if (atual != esperado) begin
            erros++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    // Model: walk the line count one step at a time towards the clamped target.
    task automatic plan(input int t);
        int  eff;
        op_t o;
        eff = (t > MAXL) ? MAXL : t;
        while (mdl_cnt < eff) begin
            o.rem = 1'b0; o.idx = mdl_cnt; o.tmo = 1'b0;
            q.push_back(o);
            mdl_cnt++;
        end
        while (mdl_cnt > eff) begin
            mdl_cnt--;
            o.rem = 1'b1; o.idx = mdl_cnt; o.tmo = 1'b0;
            q.push_back(o);
        end
        bus.linhas_alvo = 3'(t);
    endtask

    task automatic esperar_quieto(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock); #2;
            n++;
        end while (!(q.size() == 0 && !bus.ocupado && !pend) && n < budget);
        check("espera_concluida", int'(n < budget), 1);
        check("linhas_ativas_final", int'(bus.linhas_ativas), mdl_cnt);
    endtask

    // Board responder: acknowledges after a random delay, random noise when idle.
    initial begin : respondedor
        int atraso;
        bit visto;
        atraso = 0;
        visto  = 1'b0;
        bus.pronto = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (reset || mudo) begin
                bus.pronto = 1'b0;
                visto = 1'b0;
            end else if (bus.req_inserir || bus.req_remover) begin
                if (!visto) begin
                    visto  = 1'b1;
                    atraso = $urandom_range(0, 2);
                end
                if (atraso == 0) begin
                    bus.pronto = 1'b1;
                end else begin
                    atraso--;
                    bus.pronto = 1'b0;
                end
            end else begin
                visto = 1'b0;
                bus.pronto = ($urandom_range(0, 5) == 0);
            end
        end
    end

    initial begin : monitor
        int  held;
        bit  prev;
        bit  req;
        bit  rk;
        int  ridx;
        op_t o;
        held = 0; prev = 1'b0; rk = 1'b0; ridx = 0;
        forever begin
            @(negedge clock);
            ciclo++;
            if (reset) begin
                held = 0;
                pend = 1'b0;
                prev = 1'b0;
            end else begin
                req = bus.req_inserir | bus.req_remover;
                if (bus.req_inserir && bus.req_remover) ambos++;
                if (pend) begin
                    check("ativas_pos_ack", int'(bus.linhas_ativas), pend_exp);
                    pend = 1'b0;
                end
                if (req && !prev) gap = ciclo - hs_ciclo;
                if (req) begin
                    rk   = bus.req_remover;
                    ridx = int'(bus.linha_idx);
                    if (bus.pronto) begin
                        check("pedido_esperado", int'(q.size() != 0), 1);
                        if (q.size() != 0) begin
                            o = q.pop_front();
                            check("ack_tipo_remover", int'(rk), int'(o.rem));
                            check("ack_linha_idx", ridx, o.idx);
                            check("ack_sem_timeout", 0, int'(o.tmo));
                            pend = 1'b1;
                            pend_exp = o.rem ? o.idx : o.idx + 1;
                        end
                        hs_ciclo = ciclo;
                        held = 0;
                    end else begin
                        held++;
                    end
                end else if (held > 0) begin
                    check("timeout_esperado", int'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        o = q.pop_front();
                        check("tmo_marcado", 1, int'(o.tmo));
                        check("tmo_tipo_remover", int'(rk), int'(o.rem));
                        check("tmo_linha_idx", ridx, o.idx);
                        check("tmo_ativas", int'(bus.linhas_ativas), o.rem ? o.idx + 1 : o.idx);
                    end
                    check("tmo_ciclos", held, TMO);
                    check("tmo_erro", int'(bus.erro), 1);
                    held = 0;
                end
                prev = req;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : estimulo
        int n;
        bus.enable = 1'b1;
        bus.linhas_alvo = 3'd0;
        repeat (3) @(negedge clock);
        #2;
        check("rst_req_inserir", int'(bus.req_inserir), 0);
        check("rst_req_remover", int'(bus.req_remover), 0);
        check("rst_linhas_ativas", int'(bus.linhas_ativas), 0);
        check("rst_ocupado", int'(bus.ocupado), 0);
        check("rst_erro", int'(bus.erro), 0);

        // three inserts 0,1,2; no request visible right after the first edge
        plan(3);
        reset = 1'b0;
        @(negedge clock); #1;
        check("sem_req_1a_borda", int'(bus.req_inserir | bus.req_remover), 0);
        esperar_quieto(200);

        // two removes 2,1
        plan(1);
        esperar_quieto(200);

        // target raised 2 -> 5 while an insert waits for acknowledge
        mudo = 1'b1;
        plan(2);
        n = 0;
        do begin @(negedge clock); #2; n++; end while (!bus.req_inserir && n < 20);
        check("req_inserir_visto", int'(bus.req_inserir), 1);
        plan(5);
        mudo = 1'b0;
        esperar_quieto(300);

        // target above MAX_LINHAS clamps: nothing to do at the ceiling
        plan(7);
        repeat (15) @(negedge clock);
        #2;
        check("clamp_ocupado", int'(bus.ocupado), 0);
        check("clamp_ativas", int'(bus.linhas_ativas), MAXL);

        // down to zero, then cooldown spacing between two inserts
        plan(0);
        esperar_quieto(300);
        plan(2);
        esperar_quieto(200);
        check("gap_entre_pedidos", gap - 1, GAP_ESP);

        // timeout on insert idx 2, then the retry proceeds normally
        begin
            op_t o;
            o.rem = 1'b0; o.idx = mdl_cnt; o.tmo = 1'b1;
            q.push_back(o);
        end
        mudo = 1'b1;
        bus.linhas_alvo = 3'(mdl_cnt + 1);
        n = 0;
        do begin @(negedge clock); #2; n++; end while (!bus.erro && n < TMO + 10);
        check("erro_apos_timeout", int'(bus.erro), 1);
        mudo = 1'b0;
        plan(mdl_cnt + 1);
        esperar_quieto(200);
        check("erro_pegajoso", int'(bus.erro), 1);

        // enable low blocks new operations
        bus.enable = 1'b0;
        bus.linhas_alvo = 3'd0;
        repeat (10) @(negedge clock);
        #2;
        check("enable0_ocupado", int'(bus.ocupado), 0);
        check("enable0_ativas", int'(bus.linhas_ativas), mdl_cnt);
        bus.enable = 1'b1;
        plan(0);
        esperar_quieto(300);

        for (int i = 0; i < 15; i++) begin
            plan(int'($urandom_range(0, 7)));
            esperar_quieto(400);
        end
        check("erro_ainda_1", int'(bus.erro), 1);

        // asynchronous reset in the middle of a remove
        plan(MAXL);
        esperar_quieto(400);
        mudo = 1'b1;
        bus.linhas_alvo = 3'd0;
        n = 0;
        do begin @(negedge clock); #2; n++; end while (!bus.req_remover && n < 20);
        check("req_remover_visto", int'(bus.req_remover), 1);
        #1 reset = 1'b1;
        #1;
        check("arst_req_inserir", int'(bus.req_inserir), 0);
        check("arst_req_remover", int'(bus.req_remover), 0);
        check("arst_linha_idx", int'(bus.linha_idx), 0);
        check("arst_linhas_ativas", int'(bus.linhas_ativas), 0);
        check("arst_ocupado", int'(bus.ocupado), 0);
        check("arst_erro", int'(bus.erro), 0);
        q.delete();
        mdl_cnt = 0;
        repeat (2) @(negedge clock);
        mudo = 1'b0;
        reset = 1'b0;
        plan(2);
        esperar_quieto(200);

        check("req_simultaneo", ambos, 0);
        $display("Result: errors=%0d of %0d checks", erros, checks);
        $finish;
    end

endmodule
